// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM measurement block.
package pwm_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } pwm_meas_state_e;

    localparam int DUTY_W = 7;
    localparam int PCT    = 100;

    // Bits needed to count down from n-1 to 0.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_meas_if.sv
// Control inputs and measurement results of pwm_meas, bundled for the peripheral bus.
interface pwm_meas_if #(
    parameter int W = 16
) ();
    import pwm_meas_pkg::*;

    logic              en_i;
    logic              clr_i;
    logic              pwm_i;
    logic [W-1:0]      period_o;
    logic [W-1:0]      high_o;
    logic [DUTY_W-1:0] duty_o;
    logic              valid_o;
    logic              busy_o;
    logic              ovf_o;

    modport master (
        output en_i, clr_i, pwm_i,
        input  period_o, high_o, duty_o, valid_o, busy_o, ovf_o
    );

    modport slave (
        input  en_i, clr_i, pwm_i,
        output period_o, high_o, duty_o, valid_o, busy_o, ovf_o
    );

endinterface

// File: rtl/pwm_meas_seq_div.sv
// Restoring sequential divider: one quotient bit per cycle, NW cycles per run.
module seq_div
    import pwm_meas_pkg::*;
#(
    parameter int NW = 23,
    parameter int DW = 16,
    parameter int QW = NW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          start_i,
    input  logic [NW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] quot_o
);

    localparam int CW = cnt_w(NW);

    logic [NW-1:0] num_q, num_d;
    logic [DW-1:0] den_q, den_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [DW:0]   rem_sh;
    logic [DW:0]   rem_sub;
    logic          ge;

    always_comb begin
        rem_sh  = {rem_q, num_q[NW-1]};
        rem_sub = rem_sh - {1'b0, den_q};
        ge      = (rem_sh >= {1'b0, den_q});

        num_d  = num_q;
        den_d  = den_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (clr_i) begin
            num_d  = '0;
            den_d  = '0;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start_i && !busy_q) begin
            num_d  = num_i;
            den_d  = den_i;
            rem_d  = '0;
            cnt_d  = CW'(NW - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Quotient bits shift into the numerator register as it empties.
            num_d = {num_q[NW-2:0], ge};
            rem_d = ge ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            den_q  <= den_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done_o marks the final step; quot_o is the completed quotient in that cycle.
    assign done_o = busy_q && (cnt_q == '0) && !clr_i;
    assign quot_o = QW'({num_q[NW-2:0], ge});
    assign busy_o = busy_q;

endmodule

// File: rtl/pwm_meas.sv
// Measures period and high time of an asynchronous PWM input and reports the
// rounded duty percentage through a sequential divider.
//
//   state | meaning
//   IDLE  | disabled, timed out or cleared; waiting for a rising edge
//   HIGH  | counting high time (period counter also runs)
//   LOW   | counting low time; next rise completes a measurement
module pwm_meas
    import pwm_meas_pkg::*;
#(
    parameter int W = 16
) (
    input logic       clk_i,
    input logic       rst_ni,
    pwm_meas_if.slave bus
);

    localparam int           NW    = W + DUTY_W;
    localparam logic [W-1:0] P_MAX = '1;

    logic pwm_meta_q, pwm_meta_d;
    logic pwm_s_q, pwm_s_d;
    logic pwm_dly_q, pwm_dly_d;
    logic rise, fall;

    pwm_meas_state_e   state_q, state_d;
    logic [W-1:0]      p_cnt_q, p_cnt_d;
    logic [W-1:0]      h_cnt_q, h_cnt_d;
    logic [W-1:0]      p_sh_q, p_sh_d;
    logic [W-1:0]      h_sh_q, h_sh_d;
    logic [W-1:0]      period_q, period_d;
    logic [W-1:0]      high_q, high_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic              start_div;
    logic [NW-1:0]     num_w;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quot;

    always_comb begin
        pwm_meta_d = bus.pwm_i;
        pwm_s_d    = pwm_meta_q;
        pwm_dly_d  = pwm_s_q;
        rise       = pwm_s_q & ~pwm_dly_q;
        fall       = ~pwm_s_q & pwm_dly_q;
        // Adding half the period before dividing rounds to nearest percent.
        num_w      = NW'(h_cnt_q) * NW'(PCT) + NW'(p_cnt_q >> 1);
    end

    always_comb begin
        state_d   = state_q;
        p_cnt_d   = p_cnt_q;
        h_cnt_d   = h_cnt_q;
        p_sh_d    = p_sh_q;
        h_sh_d    = h_sh_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        start_div = 1'b0;

        if (bus.clr_i) begin
            state_d  = IDLE;
            p_cnt_d  = '0;
            h_cnt_d  = '0;
            p_sh_d   = '0;
            h_sh_d   = '0;
            period_d = '0;
            high_d   = '0;
            duty_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (div_done) begin
                period_d = p_sh_q;
                high_d   = h_sh_q;
                duty_d   = div_quot;
                valid_d  = 1'b1;
            end

            if (!bus.en_i) begin
                state_d = IDLE;
                p_cnt_d = '0;
                h_cnt_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_d = HIGH;
                            p_cnt_d = W'(1);
                            h_cnt_d = W'(1);
                        end
                    end
                    HIGH: begin
                        if (p_cnt_q == P_MAX) begin
                            state_d = IDLE;
                            ovf_d   = 1'b1;
                            p_cnt_d = '0;
                            h_cnt_d = '0;
                        end else if (fall) begin
                            state_d = LOW;
                            p_cnt_d = p_cnt_q + W'(1);
                        end else begin
                            p_cnt_d = p_cnt_q + W'(1);
                            h_cnt_d = h_cnt_q + W'(1);
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state_d = HIGH;
                            p_cnt_d = W'(1);
                            h_cnt_d = W'(1);
                            // A result still dividing wins; this period is dropped.
                            if (!div_busy) begin
                                start_div = 1'b1;
                                p_sh_d    = p_cnt_q;
                                h_sh_d    = h_cnt_q;
                            end
                        end else if (p_cnt_q == P_MAX) begin
                            state_d = IDLE;
                            ovf_d   = 1'b1;
                            p_cnt_d = '0;
                            h_cnt_d = '0;
                        end else begin
                            p_cnt_d = p_cnt_q + W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_meta_q <= 1'b0;
            pwm_s_q    <= 1'b0;
            pwm_dly_q  <= 1'b0;
            state_q    <= IDLE;
            p_cnt_q    <= '0;
            h_cnt_q    <= '0;
            p_sh_q     <= '0;
            h_sh_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pwm_meta_q <= pwm_meta_d;
            pwm_s_q    <= pwm_s_d;
            pwm_dly_q  <= pwm_dly_d;
            state_q    <= state_d;
            p_cnt_q    <= p_cnt_d;
            h_cnt_q    <= h_cnt_d;
            p_sh_q     <= p_sh_d;
            h_sh_q     <= h_sh_d;
            period_q   <= period_d;
            high_q     <= high_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    seq_div #(
        .NW (NW),
        .DW (W),
        .QW (DUTY_W)
    ) u_div (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (bus.clr_i),
        .start_i (start_div),
        .num_i   (num_w),
        .den_i   (p_cnt_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quot_o  (div_quot)
    );

    assign bus.period_o = period_q;
    assign bus.high_o   = high_q;
    assign bus.duty_o   = duty_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = div_busy;
    assign bus.ovf_o    = ovf_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Scoreboard bench for pwm_meas: expected reports come from rise/fall times of the driven waveform.
module tb_pwm_meas;
    import pwm_meas_pkg::*;

    localparam int W  = 16;
    localparam int W8 = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    pwm_meas_if #(.W(W))  bus16 ();
    pwm_meas_if #(.W(W8)) bus8 ();

    pwm_meas #(.W(W))  dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(bus16));
    pwm_meas #(.W(W8)) dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

    typedef struct {
        int cyc;
        int per;
        int hi;
        int duty;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   cur_per  = 0;
    int   cur_hi   = 0;
    int   cur_duty = 0;
    bit   have_prev = 0;
    bit   en_m      = 0;
    int   prev_rise = 0;
    int   prev_fall = 0;
    bit   mon_on    = 0;
    int   v8_cnt    = 0;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A rise driven in cycle c reaches the edge detector in cycle c+2.
    function automatic void model_rise(input int c);
        int   t = c + 2;
        exp_t e;
        if (!en_m) return;
        if (have_prev && (acc_q.size() == 0 || t >= acc_q[$] + W + 8)) begin
            e.per  = c - prev_rise;
            e.hi   = prev_fall - prev_rise;
            e.duty = (e.hi * PCT + e.per / 2) / e.per;
            e.cyc  = t + W + 8;
            sb_q.push_back(e);
            acc_q.push_back(t);
        end
        have_prev = 1;
        prev_rise = c;
    endfunction

    function automatic void model_clr(input int k);
        exp_t keep[$];
        foreach (sb_q[i]) if (sb_q[i].cyc <= k) keep.push_back(sb_q[i]);
        sb_q      = keep;
        acc_q     = {};
        have_prev = 0;
        cur_per   = 0;
        cur_hi    = 0;
        cur_duty  = 0;
    endfunction

    function automatic int exp_busy(input int c);
        foreach (acc_q[i]) if (c >= acc_q[i] + 1 && c <= acc_q[i] + W + 7) return 1;
        return 0;
    endfunction

    task automatic drive_period(input int h, input int p, input int drop_at = -1, input int clr_at = -1);
        for (int i = 0; i < p; i++) begin
            if (i == 0) begin
                bus16.pwm_i = 1'b1;
                model_rise(cyc);
            end
            if (i == h) begin
                bus16.pwm_i = 1'b0;
                prev_fall   = cyc;
            end
            if (i == drop_at) begin
                bus16.en_i = 1'b0;
                en_m       = 0;
                have_prev  = 0;
            end
            if (i == clr_at) bus16.clr_i = 1'b1;
            if (clr_at >= 0 && i == clr_at + 1) begin
                bus16.clr_i = 1'b0;
                model_clr(cyc - 1);
                chk("clr_period", int'(bus16.period_o), 0);
                chk("clr_high", int'(bus16.high_o), 0);
                chk("clr_duty", int'(bus16.duty_o), 0);
                chk("clr_busy", int'(bus16.busy_o), 0);
            end
            step(1);
        end
    endtask

    task automatic regap(input int n);
        bus16.en_i = 1'b0;
        en_m       = 0;
        have_prev  = 0;
        step(n);
        bus16.en_i = 1'b1;
        en_m       = 1;
        step(3);
    endtask

    initial begin
        exp_t e;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (bus16.valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("valid_unexpected", int'(bus16.valid_o), 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("period", int'(bus16.period_o), e.per);
                    chk("high", int'(bus16.high_o), e.hi);
                    chk("duty", int'(bus16.duty_o), e.duty);
                    cur_per  = e.per;
                    cur_hi   = e.hi;
                    cur_duty = e.duty;
                end
            end else begin
                chk("hold_period", int'(bus16.period_o), cur_per);
                chk("hold_high", int'(bus16.high_o), cur_hi);
                chk("hold_duty", int'(bus16.duty_o), cur_duty);
            end
            chk("busy", int'(bus16.busy_o), exp_busy(cyc));
            chk("ovf16", int'(bus16.ovf_o), 0);
        end
    end

    always @(negedge clk) if (bus8.valid_o) v8_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c2;
        int c3;
        bus16.en_i = 1'b0; bus16.clr_i = 1'b0; bus16.pwm_i = 1'b0;
        bus8.en_i  = 1'b0; bus8.clr_i  = 1'b0; bus8.pwm_i  = 1'b0;
        #2 rst_n = 1'b0;
        step(3);
        chk("rst_period", int'(bus16.period_o), 0);
        chk("rst_high", int'(bus16.high_o), 0);
        chk("rst_duty", int'(bus16.duty_o), 0);
        chk("rst_valid", int'(bus16.valid_o), 0);
        chk("rst_busy", int'(bus16.busy_o), 0);
        chk("rst_ovf", int'(bus16.ovf_o), 0);
        chk("rst_ovf8", int'(bus8.ovf_o), 0);
        rst_n = 1'b1;
        step(2);
        mon_on = 1;

        // 10/5 continuous, then 3/1, then 9/7 switching to 40/10
        regap(3);
        for (int i = 0; i < 6; i++)  drive_period(5, 10);
        for (int i = 0; i < 40; i++) drive_period(1, 3);
        for (int i = 0; i < 12; i++) drive_period(7, 9);
        for (int i = 0; i < 6; i++)  drive_period(10, 40);

        // clear in the middle of a divide
        regap(30);
        drive_period(10, 20);
        drive_period(10, 20, -1, 6);
        for (int i = 0; i < 4; i++) drive_period(10, 20);

        // enable dropped three cycles after a completing rise
        regap(30);
        drive_period(10, 20);
        drive_period(10, 20, 5);
        for (int i = 0; i < 3; i++) drive_period(10, 20);

        // random waveforms
        regap(30);
        for (int i = 0; i < 40; i++) begin
            int p = int'($urandom_range(60, 3));
            int h = int'($urandom_range(p - 1, 1));
            drive_period(h, p);
        end
        bus16.pwm_i = 1'b0;
        step(50);
        chk("sb_drain", sb_q.size(), 0);

        // W=8 timeout with constant low, then constant high
        bus8.en_i = 1'b1;
        step(3);
        bus8.pwm_i = 1'b1; step(4);
        bus8.pwm_i = 1'b0; step(6);
        c2 = cyc;
        bus8.pwm_i = 1'b1; step(4);
        bus8.pwm_i = 1'b0;
        step(200);
        chk("ovf8_early", int'(bus8.ovf_o), 0);
        while (!bus8.ovf_o && cyc < c2 + 400) step(1);
        chk("ovf8_low_cycle", cyc, c2 + 258);
        step(20);
        chk("ovf8_sticky", int'(bus8.ovf_o), 1);
        chk("ovf8_period", int'(bus8.period_o), 10);
        chk("ovf8_high", int'(bus8.high_o), 4);
        chk("ovf8_duty", int'(bus8.duty_o), 40);
        chk("v8_count", v8_cnt, 1);
        bus8.clr_i = 1'b1; step(1);
        bus8.clr_i = 1'b0;
        chk("clr8_ovf", int'(bus8.ovf_o), 0);
        chk("clr8_period", int'(bus8.period_o), 0);
        chk("clr8_duty", int'(bus8.duty_o), 0);
        step(3);
        c3 = cyc;
        bus8.pwm_i = 1'b1;
        while (!bus8.ovf_o && cyc < c3 + 400) step(1);
        chk("ovf8_high_cycle", cyc, c3 + 258);
        chk("v8_count_end", v8_cnt, 1);
        bus8.en_i  = 1'b0;
        bus8.pwm_i = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
